// File: rtl/ln_stat.sv
// Streaming LayerNorm statistics: accumulates the element sum and sum of squares over
// 2^LOG2_WORDS two-lane words, then emits the floor mean and the clamped variance.
module ln_stat #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned LOG2_WORDS = 6
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic                           i_start,
  input  logic                           i_valid,
  input  logic [DWIDTH-1:0]              i_in,
  output logic signed [DWIDTH/2-1:0]     o_mean,
  output logic [DWIDTH-1:0]              o_var,
  output logic                           o_valid,
  output logic                           o_busy
);

  localparam int unsigned HW      = DWIDTH / 2;
  localparam int unsigned SUM_W   = HW + LOG2_WORDS + 2;
  localparam int unsigned SQ_W    = DWIDTH - 1;
  localparam int unsigned SUMSQ_W = DWIDTH + LOG2_WORDS + 1;
  localparam int unsigned SH      = LOG2_WORDS + 1;
  localparam int unsigned CNT_W   = LOG2_WORDS;
  localparam int unsigned WORDS   = 2 ** LOG2_WORDS;

  typedef enum logic [1:0] {IDLE, ACC, MEAN, VAR} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic [SUMSQ_W-1:0]        sumsq_q, sumsq_d;
  logic signed [HW-1:0]      mean_r_q, mean_r_d;
  logic signed [HW-1:0]      mean_q, mean_d;
  logic [DWIDTH-1:0]         var_q, var_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;

  // Per-word lane datapath
  logic signed [HW-1:0]      lane0_c, lane1_c;
  logic signed [DWIDTH-1:0]  l0w_c, l1w_c;
  logic [SQ_W-1:0]           sq0_c, sq1_c;
  logic signed [SUM_W-1:0]   lane_sum_c;
  logic [SUMSQ_W-1:0]        lane_sq_c;

  assign lane0_c    = i_in[DWIDTH-1:HW];
  assign lane1_c    = i_in[HW-1:0];
  assign l0w_c      = DWIDTH'(lane0_c);
  assign l1w_c      = DWIDTH'(lane1_c);
  assign sq0_c      = SQ_W'(l0w_c * l0w_c);
  assign sq1_c      = SQ_W'(l1w_c * l1w_c);
  assign lane_sum_c = SUM_W'(lane0_c) + SUM_W'(lane1_c);
  assign lane_sq_c  = SUMSQ_W'(sq0_c) + SUMSQ_W'(sq1_c);

  // Floor mean and signed variance difference; negative results come from floor bias
  logic signed [HW-1:0]      mean_c;
  logic signed [DWIDTH:0]    msq_c;
  logic signed [DWIDTH:0]    ex2_c;
  logic signed [DWIDTH:0]    d_c;

  assign mean_c = HW'(sum_q >>> SH);
  assign msq_c  = (DWIDTH + 1)'(mean_r_q) * (DWIDTH + 1)'(mean_r_q);
  assign ex2_c  = $signed({1'b0, DWIDTH'(sumsq_q >> SH)});
  assign d_c    = ex2_c - msq_c;

  logic                      accept_c;
  logic [CNT_W-1:0]          cnt_base_c;
  logic signed [SUM_W-1:0]   sum_base_c;
  logic [SUMSQ_W-1:0]        sumsq_base_c;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    sumsq_d      = sumsq_q;
    mean_r_d     = mean_r_q;
    mean_d       = mean_q;
    var_d        = var_q;
    valid_d      = 1'b0;
    accept_c     = i_valid && (i_start || (state_q == ACC));
    cnt_base_c   = i_start ? '0 : cnt_q;
    sum_base_c   = i_start ? '0 : sum_q;
    sumsq_base_c = i_start ? '0 : sumsq_q;

    // i_start from any state (re)begins a vector; a live vector is aborted silently
    if (i_start) begin
      state_d = ACC;
      cnt_d   = '0;
      sum_d   = '0;
      sumsq_d = '0;
    end else begin
      case (state_q)
        MEAN: begin
          mean_r_d = mean_c;
          state_d  = VAR;
        end
        VAR: begin
          mean_d  = mean_r_q;
          var_d   = d_c[DWIDTH] ? '0 : d_c[DWIDTH-1:0];
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end

    if (accept_c) begin
      sum_d   = sum_base_c + lane_sum_c;
      sumsq_d = sumsq_base_c + lane_sq_c;
      cnt_d   = cnt_base_c + CNT_W'(1);
      if (cnt_base_c == CNT_W'(WORDS - 1)) state_d = MEAN;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sum_q    <= '0;
      sumsq_q  <= '0;
      mean_r_q <= '0;
      mean_q   <= '0;
      var_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      sumsq_q  <= sumsq_d;
      mean_r_q <= mean_r_d;
      mean_q   <= mean_d;
      var_q    <= var_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign o_mean  = mean_q;
  assign o_var   = var_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_ln_stat.sv
// Bench for ln_stat with 4-word vectors: directed cases, abort/reset, then random vectors
// checked against an integer floor-mean / clamped-variance model.
module tb_ln_stat;

  localparam int unsigned DW = 32;
  localparam int unsigned L2 = 2;
  localparam int unsigned NW = 4;

  typedef logic signed [63:0] v_t;

  logic                 clk = 1'b0;
  logic                 arst;
  logic                 i_start;
  logic                 i_valid;
  logic [DW-1:0]        i_in;
  logic signed [DW/2-1:0] o_mean;
  logic [DW-1:0]        o_var;
  logic                 o_valid;
  logic                 o_busy;

  int tests = 0;
  int fails = 0;
  int vcount = 0;

  always #5 clk = ~clk;

  ln_stat #(.DWIDTH(DW), .LOG2_WORDS(L2)) dut (
    .clk     (clk),
    .arst    (arst),
    .i_start (i_start),
    .i_valid (i_valid),
    .i_in    (i_in),
    .o_mean  (o_mean),
    .o_var   (o_var),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  task automatic check(input string tag, input v_t obs, input v_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (o_valid === 1'b1) vcount++;
  endtask

  // Reference: floor of sum/N, then max(0, floor(sumsq/N) - mean^2)
  task automatic model(input logic [DW-1:0] w[NW], output v_t m, output v_t v);
    longint s, sq, e, n, ex2, d;
    s = 0; sq = 0; n = 2 * NW;
    for (int k = 0; k < int'(NW); k++) begin
      e = longint'($signed(w[k][31:16])); s += e; sq += e * e;
      e = longint'($signed(w[k][15:0]));  s += e; sq += e * e;
    end
    if (s >= 0) m = s / n;
    else        m = -((-s + n - 1) / n);
    ex2 = sq / n;
    d = ex2 - m * m;
    v = (d < 0) ? 0 : d;
  endtask

  task automatic send_vec(input logic [DW-1:0] w[NW], input bit bubble,
                          input v_t em, input v_t ev, input string tag);
    vcount = 0;
    i_start = 1'b1; i_valid = 1'b1; i_in = w[0];
    tick();
    i_start = 1'b0;
    check({tag, " busy_acc"}, v_t'(o_busy), 1);
    for (int k = 1; k < int'(NW); k++) begin
      if (bubble) begin
        i_valid = 1'b0; i_in = $urandom;
        tick();
        check({tag, " busy_bubble"}, v_t'(o_busy), 1);
      end
      i_valid = 1'b1; i_in = w[k];
      tick();
    end
    // Words presented during MEAN/VAR must be dropped
    i_valid = 1'b1; i_in = $urandom;
    tick();
    check({tag, " valid_early"}, v_t'(o_valid), 0);
    check({tag, " busy_var"}, v_t'(o_busy), 1);
    tick();
    check({tag, " valid"}, v_t'(o_valid), 1);
    check({tag, " mean"}, v_t'(o_mean), em);
    check({tag, " var"}, v_t'(o_var), ev);
    i_valid = 1'b0;
    tick();
    check({tag, " valid_pulse"}, v_t'(o_valid), 0);
    check({tag, " busy_idle"}, v_t'(o_busy), 0);
    check({tag, " mean_hold"}, v_t'(o_mean), em);
    check({tag, " valid_count"}, v_t'(vcount), 1);
  endtask

  logic [DW-1:0] uni[NW]  = '{32'h0001_0001, 32'h0001_0001, 32'h0001_0001, 32'h0001_0001};
  logic [DW-1:0] sym[NW]  = '{32'h0002_FFFE, 32'h0002_FFFE, 32'h0002_FFFE, 32'h0002_FFFE};
  logic [DW-1:0] ramp[NW] = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};
  logic [DW-1:0] neg[NW]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
  logic [DW-1:0] rw[NW];

  initial begin
    v_t em, ev;
    arst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_in = '0;
    tick();
    check("rst mean", v_t'(o_mean), 0);
    check("rst var", v_t'(o_var), 0);
    check("rst valid", v_t'(o_valid), 0);
    check("rst busy", v_t'(o_busy), 0);
    arst = 1'b0;
    tick();

    // Idle traffic without i_start must be ignored
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_in = $urandom;
      tick();
      check("idle busy", v_t'(o_busy), 0);
      check("idle valid", v_t'(o_valid), 0);
    end
    i_valid = 1'b0;

    send_vec(uni,  1'b0, 1, 0, "uniform");
    send_vec(sym,  1'b0, 0, 4, "symmetric");
    send_vec(ramp, 1'b0, 4, 9, "ramp");
    send_vec(neg,  1'b0, -2, 0, "negclamp");
    send_vec(ramp, 1'b1, 4, 9, "ramp_bubble");

    // Abort after two words, then a full uniform vector
    i_start = 1'b1; i_valid = 1'b1; i_in = ramp[0];
    tick();
    i_start = 1'b0; i_in = ramp[1];
    tick();
    send_vec(uni, 1'b0, 1, 0, "abort");

    // Asynchronous reset in the middle of a vector
    send_vec(ramp, 1'b0, 4, 9, "pre_rst");
    i_start = 1'b1; i_valid = 1'b1; i_in = sym[0];
    tick();
    i_start = 1'b0; i_in = sym[1];
    tick();
    i_valid = 1'b0;
    #2 arst = 1'b1;
    #1;
    check("arst mean", v_t'(o_mean), 0);
    check("arst var", v_t'(o_var), 0);
    check("arst valid", v_t'(o_valid), 0);
    check("arst busy", v_t'(o_busy), 0);
    arst = 1'b0;
    vcount = 0;
    for (int k = 0; k < 4; k++) tick();
    check("arst no_valid", v_t'(vcount), 0);
    check("arst idle", v_t'(o_busy), 0);
    send_vec(uni, 1'b0, 1, 0, "post_rst");

    // Random vectors, some with full-scale lanes
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < int'(NW); k++) begin
        case ($urandom_range(0, 3))
          0:       rw[k] = {16'h8000, 16'h8000};
          1:       rw[k] = {16'h7FFF, 16'h8000};
          default: rw[k] = $urandom;
        endcase
        if (r < 12) rw[k] = $urandom;
      end
      model(rw, em, ev);
      send_vec(rw, 1'($urandom_range(0, 1)), em, ev, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ln_stat.md
Name: ln_stat

Overview:
- Streaming LayerNorm statistics stage. Sits directly downstream of the packed saturating residual-add stage and takes its o_out/o_valid word stream.
- Each input word carries two signed 16-bit lanes. Over one vector of 2^LOG2_WORDS words it accumulates the element sum and the sum of squares.
- At the end of the vector it emits the mean and the variance for the normalisation stage that follows.

Parameters:
- DWIDTH, 32, input word width: two signed DWIDTH/2-bit lanes, lane0 = [DWIDTH-1:DWIDTH/2], lane1 = [DWIDTH/2-1:0].
- LOG2_WORDS, 6, log2 of words per vector. Elements per vector N = 2^(LOG2_WORDS+1).

Ports:
- clk  input  1  clock; all state on rising edge.
- arst  input  1  reset. One clock; reset is asynchronous and active-high.
- i_start  input  1  one-cycle pulse; begins a new vector.
- i_valid  input  1  i_in carries a valid word this cycle.
- i_in  input  DWIDTH  packed two-lane signed word.
- o_mean  output  DWIDTH/2  signed mean of the last completed vector.
- o_var  output  DWIDTH  unsigned variance of the last completed vector.
- o_valid  output  1  one-cycle pulse when o_mean/o_var update.
- o_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (arst=1, asynchronous): state=IDLE, word count=0, accumulators=0, o_mean=0, o_var=0, o_valid=0, o_busy=0.
- States: IDLE, ACC, MEAN, VAR.
- IDLE:
  - i_valid is ignored.
  - On i_start: clear the sum, sum of squares and count, then go to ACC.
  - If i_valid is also high in the start cycle, that word is accepted as word 0.
- ACC:
  - Each edge with i_valid=1: sum += lane0 + lane1 (sign-extended); sumsq += lane0^2 + lane1^2; count += 1.
  - Bubbles (i_valid=0) are allowed and hold all state. Input every other cycle, as the upstream stage produces it, is the normal case.
  - The edge that accepts word 2^LOG2_WORDS-1 moves the state to MEAN.
- MEAN: one cycle.
  - mean_r = sum >>> (LOG2_WORDS+1), an arithmetic shift, i.e. floor.
  - The result always fits DWIDTH/2 signed.
  - Go to VAR.
- VAR: one cycle.
  - d = (sumsq >> (LOG2_WORDS+1)) - mean_r*mean_r, as a signed difference.
  - o_var = (d < 0) ? 0 : d. The negative case comes from floor bias.
  - o_mean = mean_r; o_valid = 1 for exactly one cycle; go to IDLE.
- Latency: o_valid rises on the 2nd rising edge after the edge that accepted the last word.
- Widths:
  - sum: DWIDTH/2+LOG2_WORDS+2 bits, signed.
  - square: DWIDTH-2+1 bits, unsigned (max (-32768)^2 = 2^30).
  - sumsq: DWIDTH+LOG2_WORDS+1 bits, unsigned.
  - No overflow is possible at these widths and no saturation is needed.
- o_mean and o_var hold their values until the next completion. Aborted vectors never update them.
- i_start while in ACC/MEAN/VAR aborts the current vector: clear everything, go to ACC, no o_valid. A same-cycle i_valid is accepted as word 0.
- arst mid-vector returns the block to reset values immediately. No o_valid is produced for the partial vector.
- i_valid in MEAN/VAR is dropped. Upstream must not present the next vector before i_start.

Test Plan (LOG2_WORDS=2: 4 words, 8 elements):
- Uniform: i_start; 4 words of 0x0001_0001 -> o_mean=1, o_var=0, o_valid one cycle, 2 edges after the last word.
- Symmetric: 4 words of 0x0002_FFFE (values 2,-2) -> sum 0, sumsq 32, o_mean=0, o_var=4.
- Ramp with floor: words 0x0001_0002, 0x0003_0004, 0x0005_0006, 0x0007_0008 -> sum 36, o_mean=4, sumsq 204, 204>>3=25, o_var=25-16=9.
- Negative clamp: 4 words of 0xFFFF_FFFE (values -1,-2) -> sum -12, o_mean=-2 (0xFFFE), sumsq>>3=2, d=2-4=-2, o_var=0.
- Bubbled input: the ramp vector with i_valid high every other cycle -> same result (4, 9); o_busy high from i_start until o_valid; inputs in IDLE are ignored.
- Abort/reset:
  - i_start, 2 words, i_start again, then 4 uniform words -> exactly one o_valid, with o_mean=1, o_var=0.
  - Separately, arst during ACC -> all outputs 0, state IDLE; the next vector completes normally.
